// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parameterised UART receiver with ready/valid word output
// Samples a synchronised rx mid-bit; completed frames are held until the consumer takes them.
module uart_rx_param #(
  parameter int CLK_RATE  = 100_000_000,
  parameter int BAUD_RATE = 1_000_000,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 areset,
  input  logic                 rx,
  input  logic                 ready,
  output logic                 data_val,
  output logic [DATA_BITS-1:0] data,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun
);

  localparam int CLKS_PER_BAUD = CLK_RATE / BAUD_RATE;
  localparam int HALF          = CLKS_PER_BAUD / 2;
  localparam logic [31:0] BAUD_LAST = (CLKS_PER_BAUD > 0) ? 32'(CLKS_PER_BAUD - 1) : 32'd0;
  localparam logic [31:0] HALF_LAST = (HALF > 0) ? 32'(HALF - 1) : 32'd0;
  localparam logic [3:0]  DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  state_t               state;
  logic                 rx_meta;
  logic                 rx_s;
  logic                 armed;
  logic [31:0]          cnt;
  logic [3:0]           bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err;
  logic                 frm_err;

  always_ff @(posedge clk) begin
    if (areset) begin
      state         <= ST_IDLE;
      rx_meta       <= 1'b1;
      rx_s          <= 1'b1;
      armed         <= 1'b0;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      par_err       <= 1'b0;
      frm_err       <= 1'b0;
      data_val      <= 1'b0;
      data          <= '0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      overrun <= 1'b0;
      if (data_val && ready) data_val <= 1'b0;

      case (state)
        ST_IDLE: begin
          cnt <= '0;
          // A start edge only counts once the line has been seen idle since the last frame.
          if (rx_s) begin
            armed <= 1'b1;
          end else if (armed) begin
            armed <= 1'b0;
            state <= ST_START;
          end
        end

        ST_START: begin
          if (cnt == HALF_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= ST_IDLE;
            end else begin
              state   <= ST_DATA;
              bit_idx <= '0;
              par_err <= 1'b0;
              frm_err <= 1'b0;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        ST_DATA: begin
          if (cnt == BAUD_LAST) begin
            cnt   <= '0;
            shreg <= {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_idx == DATA_LAST) begin
              bit_idx <= '0;
              state   <= (PARITY != 0) ? ST_PARITY : ST_STOP;
            end else begin
              bit_idx <= bit_idx + 4'd1;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        ST_PARITY: begin
          if (cnt == BAUD_LAST) begin
            cnt     <= '0;
            par_err <= (PARITY == 1) ? ~(^{shreg, rx_s}) : (^{shreg, rx_s});
            state   <= ST_STOP;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        ST_STOP: begin
          if (cnt == BAUD_LAST) begin
            cnt <= '0;
            if (bit_idx == STOP_LAST) begin
              state   <= ST_IDLE;
              bit_idx <= '0;
              // A held, unaccepted word wins over the new frame.
              if (!data_val || ready) begin
                data_val      <= 1'b1;
                data          <= shreg;
                parity_error  <= par_err;
                framing_error <= frm_err | ~rx_s;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frm_err <= frm_err | ~rx_s;
              bit_idx <= bit_idx + 4'd1;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - bench for uart_rx_param across 8N1, 8E1, 8N2 and 7N1 builds
// A frame-level model predicts each presented word, its completion cycle and any overrun.
module tb_uart_rx_param;

  localparam int CLK_HZ = 100_000_000;
  localparam int BAUD   = 10_000_000;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int HALF   = CPB / 2;

  logic       clk;
  logic       areset;
  logic       ready;
  logic [3:0] rx_l;
  logic [3:0] dv, pe, fe, ov;
  logic [7:0] d0, d1, d2;
  logic [6:0] d3;
  logic [8:0] dat [4];

  assign dat[0] = {1'b0, d0};
  assign dat[1] = {1'b0, d1};
  assign dat[2] = {1'b0, d2};
  assign dat[3] = {2'b00, d3};

  uart_rx_param #(.CLK_RATE(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .areset(areset), .rx(rx_l[0]), .ready(ready), .data_val(dv[0]), .data(d0),
    .parity_error(pe[0]), .framing_error(fe[0]), .overrun(ov[0]));
  uart_rx_param #(.CLK_RATE(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .areset(areset), .rx(rx_l[1]), .ready(ready), .data_val(dv[1]), .data(d1),
    .parity_error(pe[1]), .framing_error(fe[1]), .overrun(ov[1]));
  uart_rx_param #(.CLK_RATE(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .areset(areset), .rx(rx_l[2]), .ready(ready), .data_val(dv[2]), .data(d2),
    .parity_error(pe[2]), .framing_error(fe[2]), .overrun(ov[2]));
  uart_rx_param #(.CLK_RATE(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(0), .STOP_BITS(1)) u_7n1 (
    .clk(clk), .areset(areset), .rx(rx_l[3]), .ready(ready), .data_val(dv[3]), .data(d3),
    .parity_error(pe[3]), .framing_error(fe[3]), .overrun(ov[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int db_of(input int i);
    return (i == 3) ? 7 : 8;
  endfunction
  function automatic int par_of(input int i);
    return (i == 1) ? 2 : 0;
  endfunction
  function automatic int stop_of(input int i);
    return (i == 2) ? 2 : 1;
  endfunction

  int         chk_cnt = 0;
  int         err_cnt = 0;
  int         cyc = 0;
  logic       mon_on = 1'b0;

  // Frame-level model: one scheduled completion per instance, plus the word being offered.
  int         sch_cyc [4] = '{-1, -1, -1, -1};
  logic [8:0] sch_w   [4];
  logic [3:0] sch_pe, sch_fe;
  logic [3:0] m_val = '0, m_ovr = '0, m_pe = '0, m_fe = '0;
  logic [8:0] m_word  [4];

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      if (areset) begin
        m_val[i] = 1'b0;
        m_ovr[i] = 1'b0;
      end else begin
        m_ovr[i] = 1'b0;
        if (sch_cyc[i] == cyc) begin
          if (m_val[i] && !ready) begin
            m_ovr[i] = 1'b1;
          end else begin
            m_val[i]  = 1'b1;
            m_word[i] = sch_w[i];
            m_pe[i]   = sch_pe[i];
            m_fe[i]   = sch_fe[i];
          end
        end else if (m_val[i] && ready) begin
          m_val[i] = 1'b0;
        end
      end
    end
  end

  // Observed-side statistics gathered alongside the per-cycle comparison.
  int         hs_cnt   [4] = '{0, 0, 0, 0};
  int         ovr_cnt  [4] = '{0, 0, 0, 0};
  int         dv_cyc   [4] = '{0, 0, 0, 0};
  int         rise_cyc [4] = '{0, 0, 0, 0};
  int         fall_cyc [4] = '{0, 0, 0, 0};
  logic [8:0] hs_word  [4];
  logic [3:0] hs_pe = '0, hs_fe = '0;
  logic [3:0] p_dv = '0, p_pe = '0, p_fe = '0;
  logic [8:0] p_dat    [4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, need 0x%0h", name, got, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 4; i++) begin
      if (p_dv[i] && ready) begin
        hs_cnt[i]++;
        hs_word[i] = p_dat[i];
        hs_pe[i]   = p_pe[i];
        hs_fe[i]   = p_fe[i];
      end
      chk_cnt++;
      if (dv[i] !== m_val[i] || ov[i] !== m_ovr[i] ||
          (m_val[i] && (dat[i] !== m_word[i] || pe[i] !== m_pe[i] || fe[i] !== m_fe[i]))) begin
        err_cnt++;
        $display("FAIL cmp_inst%0d @cyc %0d: got val=%b data=0x%0h pe=%b fe=%b ovr=%b, need val=%b data=0x%0h pe=%b fe=%b ovr=%b",
                 i, cyc, dv[i], dat[i], pe[i], fe[i], ov[i], m_val[i], m_word[i], m_pe[i], m_fe[i], m_ovr[i]);
      end
      if (ov[i] === 1'b1) ovr_cnt[i]++;
      if (dv[i] === 1'b1) begin
        dv_cyc[i]++;
        if (!p_dv[i]) rise_cyc[i] = cyc;
      end
      p_dv[i]  = dv[i];
      p_dat[i] = dat[i];
      p_pe[i]  = pe[i];
      p_fe[i]  = fe[i];
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    if (mon_on) compare_all();
  endtask

  // Drives one frame on instance i; rdy_pulse raises ready only in the completion cycle,
  // rst_at >= 0 pulses areset at that cycle offset and the frame is then expected to vanish.
  task automatic send(input int i, input logic [8:0] w, input logic pbit, input logic [1:0] stops,
                      input bit rdy_pulse, input int rst_at, input int gap);
    logic bits[$];
    logic x;
    logic f;
    int   done;
    bits.push_back(1'b0);
    x = pbit;
    for (int k = 0; k < db_of(i); k++) begin
      bits.push_back(w[k]);
      x = x ^ w[k];
    end
    if (par_of(i) != 0) bits.push_back(pbit);
    f = 1'b0;
    for (int k = 0; k < stop_of(i); k++) begin
      bits.push_back(stops[k]);
      if (!stops[k]) f = 1'b1;
    end
    tick();
    done = cyc + 3 + HALF + CPB * (bits.size() - 1);
    if (rst_at < 0) begin
      sch_w[i]  = w;
      sch_pe[i] = (par_of(i) == 1) ? ~x : (par_of(i) == 2) ? x : 1'b0;
      sch_fe[i] = f;
      sch_cyc[i] = done;
    end
    fall_cyc[i] = cyc;
    for (int c = 0; c < bits.size() * CPB; c++) begin
      if (c > 0) tick();
      rx_l[i] = bits[c / CPB];
      if (rdy_pulse) ready = (cyc + 1 == done);
      if (rst_at >= 0) areset = (c == rst_at);
    end
    tick();
    rx_l[i] = 1'b1;
    areset  = 1'b0;
    repeat (gap) tick();
  endtask

  initial begin
    areset = 1'b1;
    ready  = 1'b1;
    rx_l   = 4'hF;
    repeat (3) tick();
    for (int i = 0; i < 4; i++)
      check($sformatf("reset_outs_inst%0d", i), {dv[i], ov[i], pe[i], fe[i], dat[i]}, 32'h0);
    mon_on = 1'b1;
    areset = 1'b0;
    repeat (5) tick();

    // 8N1 0xA5 with ready held high
    send(0, 9'h0A5, 1'b0, 2'b11, 1'b0, -1, 20);
    check("a5_count", hs_cnt[0], 1);
    check("a5_data", hs_word[0], 32'hA5);
    check("a5_flags", {hs_pe[0], hs_fe[0]}, 0);
    check("a5_valid_one_cycle", dv_cyc[0], 1);

    // 8E1 parity: 0x07 has three ones, so parity bit 0 is an even-parity error
    send(1, 9'h007, 1'b0, 2'b11, 1'b0, -1, 20);
    check("par0_data", hs_word[1], 32'h07);
    check("par0_pe", hs_pe[1], 1);
    send(1, 9'h007, 1'b1, 2'b11, 1'b0, -1, 20);
    check("par1_pe", hs_pe[1], 0);
    check("par_count", hs_cnt[1], 2);

    // 8N2: bad second stop bit, then a 200-cycle break
    send(2, 9'h03C, 1'b0, 2'b01, 1'b0, -1, 20);
    check("stop2_data", hs_word[2], 32'h3C);
    check("stop2_fe", hs_fe[2], 1);
    tick();
    sch_w[2]   = 9'h000;
    sch_pe[2]  = 1'b0;
    sch_fe[2]  = 1'b1;
    sch_cyc[2] = cyc + 3 + HALF + CPB * 10;
    rx_l[2]    = 1'b0;
    repeat (200) tick();
    rx_l[2] = 1'b1;
    repeat (40) tick();
    check("break_count", hs_cnt[2], 2);
    check("break_data", hs_word[2], 0);
    check("break_fe", hs_fe[2], 1);

    // 3-cycle low glitch must be rejected, then a normal frame
    tick();
    rx_l[0] = 1'b0;
    repeat (3) tick();
    rx_l[0] = 1'b1;
    repeat (30) tick();
    check("glitch_no_frame", hs_cnt[0] + dv_cyc[0], 2);
    send(0, 9'h05A, 1'b0, 2'b11, 1'b0, -1, 20);
    check("after_glitch_data", hs_word[0], 32'h5A);

    // Overrun: consumer stalled, second frame dropped
    ready = 1'b0;
    send(0, 9'h011, 1'b0, 2'b11, 1'b0, -1, 20);
    check("hold_11", {dv[0], dat[0]}, 32'h211);
    send(0, 9'h022, 1'b0, 2'b11, 1'b0, -1, 20);
    check("still_11", {dv[0], dat[0]}, 32'h211);
    check("overrun_once", ovr_cnt[0], 1);
    // Same again, but the consumer takes 0x11 in the completion cycle
    send(0, 9'h022, 1'b0, 2'b11, 1'b1, -1, 20);
    check("swap_22", {dv[0], dat[0]}, 32'h222);
    check("swap_took_11", hs_word[0], 32'h11);
    check("swap_no_overrun", ovr_cnt[0], 1);

    // 7N1: reset during data bit 3 abandons the frame
    ready = 1'b1;
    tick();
    send(3, 9'h078, 1'b0, 2'b11, 1'b0, 4 * CPB + HALF, 20);
    check("rst_outs_inst3", {dv[3], ov[3], pe[3], fe[3], dat[3]}, 32'h0);
    check("rst_data_inst0", dat[0], 32'h0);
    check("rst_no_frame", hs_cnt[3], 0);
    send(3, 9'h055, 1'b0, 2'b11, 1'b0, -1, 20);
    check("post_rst_data", hs_word[3], 32'h55);
    check("post_rst_count", hs_cnt[3], 1);
    chk_cnt++;
    if (rise_cyc[3] - fall_cyc[3] > (2 + 1 + 7 + 1) * CPB + 4) begin
      err_cnt++;
      $display("FAIL latency_7n1: got %0d cycles, need <= %0d", rise_cyc[3] - fall_cyc[3], (2 + 1 + 7 + 1) * CPB + 4);
    end

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 The block SHALL have parameter CLK_RATE, default 100_000_000, meaning clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 1_000_000, meaning line rate in baud.
REQ-003 The block SHALL have parameter DATA_BITS, default 8, meaning data bits per frame; the legal range is 5..9.
REQ-004 The block SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-005 The block SHALL have parameter STOP_BITS, default 1, meaning stop bits checked per frame; the legal values are 1 and 2.
REQ-006 The block SHALL have these ports:
- clk, input, 1 bit: sole clock; all logic is on its rising edge.
- areset, input, 1 bit: synchronous, active-high reset.
- rx, input, 1 bit: asynchronous serial line; idles high.
- ready, input, 1 bit: consumer accepts the word when data_val=1 and ready=1.
- data_val, output, 1 bit: received word valid.
- data, output, DATA_BITS bits: received word, LSB received first.
- parity_error, output, 1 bit: the presented word failed the parity check.
- framing_error, output, 1 bit: a stop bit of the presented word sampled 0.
- overrun, output, 1 bit: one-cycle pulse when a completed frame is dropped.

Function
REQ-007 rx SHALL pass through a 2-flop synchronizer, giving rx_s; all sampling SHALL use rx_s.
REQ-008 CLKS_PER_BAUD SHALL equal CLK_RATE/BAUD_RATE, truncated; HALF SHALL equal CLKS_PER_BAUD/2, truncated; the clock counter SHALL be 32 bits.
REQ-009 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP.
REQ-010 IDLE SHALL go to START on rx_s=0, but only after rx_s=1 has been seen since the last frame ended (arm flag), so a held-low line cannot retrigger.
REQ-011 START SHALL sample rx_s HALF cycles after entry.
- If the sample is 1: return to IDLE with no output (glitch reject).
- If the sample is 0: go to DATA.
REQ-012 DATA SHALL sample one bit every CLKS_PER_BAUD cycles, measured from the START sample.
- Bits SHALL be stored LSB first.
- After DATA_BITS samples, go to PARITY if PARITY!=0, else to STOP.
REQ-013 PARITY SHALL sample one bit after CLKS_PER_BAUD cycles.
- Odd mode: the error condition is XOR(data, bit)=0.
- Even mode: the error condition is XOR(data, bit)=1.
REQ-014 STOP SHALL sample STOP_BITS bits at CLKS_PER_BAUD spacing; any 0 sample SHALL set the frame's framing error; after the last sample the FSM SHALL enter IDLE.
REQ-015 On the cycle after the last stop sample, the frame SHALL be presented:
- data_val=1.
- data, parity_error and framing_error are loaded together.
- Frames with errors are still delivered.
REQ-016 data, parity_error and framing_error SHALL hold stable while data_val=1 and ready=0.
REQ-017 data_val SHALL clear on the cycle after data_val=1 and ready=1, unless a new frame loads in that same cycle.
REQ-018 If a frame completes while data_val=1 and ready=1 in the same cycle, the new frame SHALL load, data_val SHALL stay 1, and overrun SHALL stay 0.
REQ-019 If a frame completes while data_val=1 and ready=0:
- The held word and its flags SHALL be retained.
- The new frame SHALL be discarded.
- overrun SHALL pulse high for exactly one cycle.
REQ-020 A break (rx held low for a whole frame or longer) SHALL deliver data=0 with framing_error=1, followed by no further frames until rx_s returns to 1.
REQ-021 With DATA_BITS<8 and no parity, a frame with ready=1 SHALL be complete and presented within (2 + 1 + DATA_BITS + STOP_BITS) x CLKS_PER_BAUD + 4 cycles of the rx falling edge.

Reset
REQ-022 When areset=1 at a clock edge, the block SHALL set:
- state=IDLE;
- data_val=0, data=0, parity_error=0, framing_error=0, overrun=0;
- counters=0;
- synchronizer flops=1;
- arm flag=0.
REQ-023 Reset asserted mid-frame SHALL abandon the frame with no output; reception SHALL resume with the first falling edge after rx_s=1 is seen.

Verification
(Bench setup for REQ-024..029: CLK_RATE=100_000_000, BAUD_RATE=10_000_000, so CLKS_PER_BAUD=10 and HALF=5, unless stated otherwise.)
REQ-024 8N1, send 0xA5, ready=1 -> data_val high for 1 cycle, data=0xA5, parity_error=0, framing_error=0.
REQ-025 PARITY=2, DATA_BITS=8, send 0x07 with parity bit 0 -> data=0x07, parity_error=1; resend with parity bit 1 -> parity_error=0.
REQ-026 STOP_BITS=2, send 0x3C with second stop bit 0 -> data=0x3C, framing_error=1; rx held low for 200 cycles -> exactly one frame, data=0x00, framing_error=1.
REQ-027 rx low pulse of 3 cycles -> no data_val, FSM back in IDLE; then a valid 0x5A -> data=0x5A.
REQ-028 ready=0, send 0x11 then 0x22 -> data stays 0x11, overrun pulses once at the 0x22 completion; repeat with ready=1 in the completion cycle -> data=0x22, no overrun.
REQ-029 DATA_BITS=7 with areset pulsed during bit 3 of a frame -> all outputs 0; the next frame, 0x55, is received correctly.
